// File: rtl/indirect_csr_bridge_if.sv
// Host window and downstream CSR target signals for indirect_csr_bridge.
// slave is the bridge side; master is the host/target side that drives the bridge.
interface indirect_csr_bridge_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              host_wr;
  logic              host_rd;
  logic [4:0]        host_addr;
  logic [63:0]       host_wdata;
  logic              host_rdvalid;
  logic [63:0]       host_rddata;
  logic              tgt_req_valid;
  logic              tgt_req_ready;
  logic              tgt_req_write;
  logic [ADDR_W-1:0] tgt_req_addr;
  logic [63:0]       tgt_req_wdata;
  logic              tgt_rsp_valid;
  logic [63:0]       tgt_rsp_rdata;

  modport slave (
    input  host_wr, host_rd, host_addr, host_wdata,
    input  tgt_req_ready, tgt_rsp_valid, tgt_rsp_rdata,
    output host_rdvalid, host_rddata,
    output tgt_req_valid, tgt_req_write, tgt_req_addr, tgt_req_wdata
  );

  modport master (
    output host_wr, host_rd, host_addr, host_wdata,
    output tgt_req_ready, tgt_rsp_valid, tgt_rsp_rdata,
    input  host_rdvalid, host_rddata,
    input  tgt_req_valid, tgt_req_write, tgt_req_addr, tgt_req_wdata
  );
endinterface

// File: rtl/indirect_csr_bridge.sv
// Indirect CSR bridge: host programs a CTRL/ADDR/WDATA/RDATA window, the bridge issues one
// read or write to a 64-bit CSR target and returns status/data, aborting on timeout.
module indirect_csr_bridge #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst,
  indirect_csr_bridge_if.slave bus
);
  localparam int unsigned       TimerW    = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              done_q;
  logic              tmo_q;
  logic              ovr_q;
  logic              op_wr_q;
  logic              rdvalid_q;
  logic [63:0]       rddata_q;
  logic              req_valid_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [63:0]       req_wdata_q;

  logic              busy;
  logic              wr_ctrl;
  logic              wr_addr;
  logic              wr_wdata;
  logic              start_any;
  logic              launch;
  logic              ovr_set;
  logic              clr;
  logic              timer_zero;
  logic [TimerW-1:0] timer_next;
  logic [63:0]       rd_mux;

  assign busy       = (state_q != StIdle);
  assign wr_ctrl    = bus.host_wr && (bus.host_addr == 5'h00);
  assign wr_addr    = bus.host_wr && (bus.host_addr == 5'h08);
  assign wr_wdata   = bus.host_wr && (bus.host_addr == 5'h10);
  assign start_any  = wr_ctrl && (bus.host_wdata[0] || bus.host_wdata[1]);
  assign launch     = !busy && wr_ctrl && (bus.host_wdata[0] ^ bus.host_wdata[1]);
  assign clr        = wr_ctrl && bus.host_wdata[7];
  // Overrun: any start or window write while busy, or an ambiguous double start in idle.
  assign ovr_set    = (busy && (start_any || wr_addr || wr_wdata)) ||
                      (!busy && wr_ctrl && bus.host_wdata[0] && bus.host_wdata[1]);
  assign timer_zero = (timer_q == '0);
  // Saturates so a handshake on the final cycle leaves no wrapped budget behind.
  assign timer_next = timer_zero ? '0 : timer_q - TimerW'(1);

  always_comb begin
    rd_mux = '0;
    case (bus.host_addr)
      5'h00:   rd_mux = {59'd0, op_wr_q, ovr_q, tmo_q, done_q, busy};
      5'h08:   rd_mux = 64'(addr_q);
      5'h10:   rd_mux = wdata_q;
      5'h18:   rd_mux = rdata_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
      op_wr_q     <= 1'b0;
      rdvalid_q   <= 1'b0;
      rddata_q    <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      rdvalid_q <= bus.host_rd;
      rddata_q  <= bus.host_rd ? rd_mux : '0;

      if (!busy && wr_addr)  addr_q  <= bus.host_wdata[ADDR_W-1:0];
      if (!busy && wr_wdata) wdata_q <= bus.host_wdata;

      // Clears first so that a same-cycle completion below wins.
      if (clr) begin
        done_q <= 1'b0;
        tmo_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (ovr_set) ovr_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (launch) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
            req_write_q <= bus.host_wdata[0];
            req_addr_q  <= {addr_q[ADDR_W-1:3], 3'b000};
            req_wdata_q <= wdata_q;
            op_wr_q     <= bus.host_wdata[0];
            timer_q     <= TimerLoad;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
          end
        end
        StReq: begin
          timer_q <= timer_next;
          if (bus.tgt_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end else if (timer_zero) begin
            req_valid_q <= 1'b0;
            state_q     <= StIdle;
            done_q      <= 1'b1;
            tmo_q       <= 1'b1;
            if (!op_wr_q) rdata_q <= '1;
          end
        end
        StWait: begin
          timer_q <= timer_next;
          if (bus.tgt_rsp_valid) begin
            if (!op_wr_q) rdata_q <= bus.tgt_rsp_rdata;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (timer_zero) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            if (!op_wr_q) rdata_q <= '1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.host_rdvalid  = rdvalid_q;
  assign bus.host_rddata   = rddata_q;
  assign bus.tgt_req_valid = req_valid_q;
  assign bus.tgt_req_write = req_write_q;
  assign bus.tgt_req_addr  = req_addr_q;
  assign bus.tgt_req_wdata = req_wdata_q;
endmodule
